// File: rtl/line_buffer_9x9.sv
// Cascaded 8-row line buffer that emits one 9-pixel column per accepted pixel once 8 rows are stored.
// Optional feature: define LINE_BUFFER_ROW_INDEX_EN to add row_idx_o (image row of the window centre minus 4).
module line_buffer_9x9 #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          done_i,
    input  logic [DATA_WIDTH-1:0]         data_i,
    output logic [DATA_WIDTH-1:0]         data0_o,
    output logic [DATA_WIDTH-1:0]         data1_o,
    output logic [DATA_WIDTH-1:0]         data2_o,
    output logic [DATA_WIDTH-1:0]         data3_o,
    output logic [DATA_WIDTH-1:0]         data4_o,
    output logic [DATA_WIDTH-1:0]         data5_o,
    output logic [DATA_WIDTH-1:0]         data6_o,
    output logic [DATA_WIDTH-1:0]         data7_o,
    output logic [DATA_WIDTH-1:0]         data8_o,
`ifdef LINE_BUFFER_ROW_INDEX_EN
    output logic [$clog2(IMG_HEIGHT)-1:0] row_idx_o,
`endif
    output logic                          done_o,
    output logic                          frame_done_o
);

    localparam int NUM_ROWS = 8;
    localparam int CW       = $clog2(IMG_WIDTH);
    localparam int RW       = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_FILL_LAST = RW'(NUM_ROWS - 1);
    localparam logic [RW-1:0] ROW_WIN       = RW'(NUM_ROWS);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic                    done_q, done_d;
    logic                    accept;
    logic                    last_col;
    logic                    last_row;

    logic [DATA_WIDTH-1:0]   row_mem [NUM_ROWS][IMG_WIDTH];
    logic [DATA_WIDTH-1:0]   tap     [NUM_ROWS];
    logic [DATA_WIDTH-1:0]   data_q  [NUM_ROWS+1];

    // The DONE cycle swallows any pixel offered, so acceptance excludes it.
    assign accept   = done_i && (state_q != DONE);
    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);

    always_comb begin
        for (int k = 0; k < NUM_ROWS; k++) begin
            tap[k] = row_mem[k][col_q];
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        done_d  = 1'b0;

        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (accept && last_col && (row_q == ROW_FILL_LAST)) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                done_d = accept;
                if (accept && last_col && last_row) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the row memories carry no reset; stale contents stay hidden because done_o is low until 8 fresh rows exist.
    always_ff @(posedge clk) begin
        if (rst && accept) begin
            row_mem[0][col_q] <= data_i;
            for (int k = 1; k < NUM_ROWS; k++) begin
                row_mem[k][col_q] <= tap[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k <= NUM_ROWS; k++) begin
                data_q[k] <= '0;
            end
        end else if (accept) begin
            data_q[0] <= data_i;
            for (int k = 1; k <= NUM_ROWS; k++) begin
                data_q[k] <= tap[k-1];
            end
        end
    end

`ifdef LINE_BUFFER_ROW_INDEX_EN
    logic [RW-1:0] row_idx_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            row_idx_q <= '0;
        end else if (accept) begin
            row_idx_q <= (row_q >= ROW_WIN) ? row_q - ROW_WIN : '0;
        end
    end

    assign row_idx_o = row_idx_q;
`endif

    assign data0_o      = data_q[0];
    assign data1_o      = data_q[1];
    assign data2_o      = data_q[2];
    assign data3_o      = data_q[3];
    assign data4_o      = data_q[4];
    assign data5_o      = data_q[5];
    assign data6_o      = data_q[6];
    assign data7_o      = data_q[7];
    assign data8_o      = data_q[8];
    assign done_o       = done_q;
    assign frame_done_o = (state_q == DONE);

endmodule

// File: doc/line_buffer_9x9.md
LINE_BUFFER_9X9 -- requirements
Module: line_buffer_9x9

Interface
REQ-001 SHALL: parameter DATA_WIDTH, default 8, bits per pixel.
REQ-002 SHALL: parameter IMG_WIDTH, default 640, pixels per row.
REQ-003 SHALL: parameter IMG_HEIGHT, default 480, rows per frame.
REQ-004 SHALL: clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL: rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL: done_i  input  1  input pixel valid; one pixel accepted per cycle when high.
REQ-007 SHALL: data_i  input  DATA_WIDTH  raster-order pixel, row-major.
REQ-008 SHALL: data0_o..data8_o  output  DATA_WIDTH each  one 9-pixel column; data0_o = current row, dataK_o = same column K rows above.
REQ-009 SHALL: done_o  output  1  column valid strobe; drives the 9x9 window buffer done_i.
REQ-010 SHALL: frame_done_o  output  1  one-cycle pulse after last pixel of frame.

Function
REQ-011 SHALL: col_cnt (0..IMG_WIDTH-1) advance only on accepted pixel; wrap to 0 after IMG_WIDTH-1 and increment row_cnt (0..IMG_HEIGHT-1).
REQ-012 SHALL: contain 8 row memories of IMG_WIDTH x DATA_WIDTH in cascade; on an accepted pixel each memory is read at col_cnt then written (read-before-write) with the value entering it: memory 0 gets data_i, memory K gets memory K-1 read data.
REQ-013 SHALL: data0_o..data8_o register data_i and the 8 read values, latency exactly 1 cycle from acceptance.
REQ-014 SHALL: FSM states IDLE, FILL, STREAM, DONE.
REQ-015 SHALL: IDLE -> FILL on first accepted pixel; FILL -> STREAM when row_cnt wraps from 7 to 8; STREAM -> DONE on accepted pixel with col_cnt = IMG_WIDTH-1 and row_cnt = IMG_HEIGHT-1; DONE -> IDLE unconditionally next cycle.
REQ-016 SHALL: done_o = 1 for exactly one cycle per pixel accepted in STREAM (row_cnt >= 8, including the last pixel); 0 in IDLE, FILL, DONE.
REQ-017 SHALL: frame_done_o = 1 only in DONE; counters cleared to 0 on entry to DONE.
REQ-018 SHALL: done_i gaps (done_i = 0) freeze counters, memories and data outputs; done_o = 0 during gaps.
REQ-019 SHALL: done_i asserted while in DONE be ignored (pixel dropped, no counter change).
REQ-020 SHALL: memory contents not be cleared between frames; frame 2 rows 0..7 produce no done_o, so stale data is never exposed.
REQ-021 SHALL: sustain one pixel per cycle with done_i held high, no bubbles except the DONE cycle.

Reset
REQ-022 SHALL: rst = 0 at a clock edge force state IDLE, col_cnt = 0, row_cnt = 0, data0_o..data8_o = 0, done_o = 0, frame_done_o = 0.
REQ-023 SHALL: reset mid-frame abort the frame; next accepted pixel is treated as row 0, column 0; memory contents undefined but unobservable per REQ-020.

Configuration
REQ-024 SHALL: macro LINE_BUFFER_ROW_INDEX_EN, when defined, add output row_idx_o (width clog2(IMG_HEIGHT)) registered alongside data outputs, equal to the image row of data0_o minus 8 (the window centre row minus 4), reset 0.
REQ-025 SHALL: without LINE_BUFFER_ROW_INDEX_EN, port row_idx_o and its logic be absent; all other behaviour identical.

Verification (IMG_WIDTH=16, IMG_HEIGHT=12, DATA_WIDTH=8)
REQ-026 SHALL: continuous frame, pixel = row*16+col -> done_o first high 1 cycle after pixel 128 accepted, data0_o=128, data8_o=0; exactly 64 done_o pulses total.
REQ-027 SHALL: same frame -> frame_done_o single pulse 1 cycle after pixel 191 accepted; last column data0_o=191, data1_o=175, data8_o=63.
REQ-028 SHALL: done_i toggled 1/0 every cycle -> identical data/done_o sequence as REQ-026, done_o only following high cycles.
REQ-029 SHALL: rst=0 for one cycle at row 9 column 5, then a full new frame -> no done_o before new row 8; outputs match REQ-026.
REQ-030 SHALL: done_i held high through DONE cycle -> that pixel dropped; next frame row 0 col 0 is the following pixel; with LINE_BUFFER_ROW_INDEX_EN, row_idx_o = 0 on first done_o and 3 on last.
